// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared scan states and active-low hex segment table for the display drivers
package seg_disp_pkg;
    typedef enum logic {SHOW, BLANK} state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational hex nibble to active-low {g,f,e,d,c,b,a} segment pattern
module hex_seg_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/seg_mux_n.sv
// seg_mux_n: N-digit multiplexed 7-segment driver with blanking gap; SEG_MUX_DIM_EN adds frame-sampled brightness
module seg_mux_n
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
`ifdef SEG_MUX_DIM_EN
    input  logic [3:0]              bright_i,
`endif
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [6:0]              seg_n,
    output logic                    frame_done,
    output logic                    pending_o
);
    localparam int TMAX  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int TW    = $clog2(TMAX > 2 ? TMAX : 2);
    localparam int IW    = $clog2(NUM_DIGITS);
    localparam int BLAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    state_t                  state, state_nx;
    logic [TW-1:0]           tick, tick_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic                    adv, boundary, lit, on;
    logic [4*NUM_DIGITS-1:0] active, pending;
    logic [6:0]              cur_seg;

    hex_seg_decode u_dec (.hex(active[4*idx +: 4]), .seg(cur_seg));

    // scan position registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SHOW;
            tick  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            tick  <= tick_nx;
            idx   <= idx_nx;
        end
    end

    // slot timing: SHOW dwell, optional BLANK gap, digit advance and frame wrap
    always_comb begin
        state_nx = state;
        tick_nx  = tick + 1'b1;
        adv      = 1'b0;
        if (state == SHOW && tick == TW'(REFRESH_DIV - 1)) begin
            tick_nx  = '0;
            adv      = (BLANK_CYCLES == 0);
            state_nx = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end else if (state == BLANK && tick == TW'(BLAST)) begin
            tick_nx  = '0;
            adv      = 1'b1;
            state_nx = SHOW;
        end
        boundary = adv && idx == IW'(NUM_DIGITS - 1);
        idx_nx   = !adv ? idx : boundary ? '0 : idx + 1'b1;
    end

`ifdef SEG_MUX_DIM_EN
    logic [3:0] bright_q;

    // brightness only changes between frames so a scan never mixes two levels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bright_q <= 4'hF;
        else if (boundary)
            bright_q <= bright_i;
    end

    assign lit = 32'(tick) < (((32'(bright_q) + 32'd1) * 32'(REFRESH_DIV)) >> 4);
`else
    assign lit = 1'b1;
`endif

    assign on = state == SHOW && digit_en_i[idx] && lit;

    // registered drive: lit digit gets its anode low and decoded segments, otherwise everything dark
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anode_n    <= '1;
            seg_n      <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            anode_n    <= on ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg_n      <= on ? cur_seg : SEG_BLANK;
            frame_done <= boundary;
        end
    end

    // double buffer: loads wait in pending and move to active only at the frame wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active    <= '0;
            pending   <= '0;
            pending_o <= 1'b0;
        end else if (boundary) begin
            active    <= load_i ? data_i : pending_o ? pending : active;
            pending_o <= 1'b0;
        end else if (load_i) begin
            pending   <= data_i;
            pending_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg_mux_n.sv
// tb_seg_mux_n: scoreboard bench for seg_mux_n with 4 digits, 8-clock dwell, 2-clock blank
module tb_seg_mux_n;
    localparam int ND = 4, RD = 8, BC = 2, SL = RD + BC, FL = ND * SL;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  en;
        logic [4:0]  lit;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b0, load_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [3:0]  digit_en_i = 4'hF;
`ifdef SEG_MUX_DIM_EN
    logic [3:0]  bright_i = 4'hF;
`endif
    logic [3:0]  anode_n;
    logic [6:0]  seg_n;
    logic        frame_done, pending_o;

    exp_t        exp_q[$];
    exp_t        e;
    int          tests = 0, fails = 0, bad, fc;
    logic        pend_tb = 1'b0, fd_end;
    logic [4:0]  lit_now = 5'd8;
    logic [3:0]  an_cap [FL];
    logic [6:0]  sg_cap [FL];
    logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_mux_n #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .data_i(data_i), .load_i(load_i), .digit_en_i(digit_en_i),
`ifdef SEG_MUX_DIM_EN
        .bright_i(bright_i),
`endif
        .anode_n(anode_n), .seg_n(seg_n), .frame_done(frame_done), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] exp_out(input exp_t x, input int c);
        int d, p;
        logic [15:0] dv;
        d  = c / SL;
        p  = c % SL;
        dv = x.data;
        if (p < int'(x.lit) && x.en[d])
            return {~(4'b0001 << d), hex_tab[dv[4*d +: 4]]};
        return {4'hF, 7'h7F};
    endfunction

    task automatic grab_frame();
        for (int c = 0; c < FL; c++) begin
            @(negedge clk);
            an_cap[c] = anode_n;
            sg_cap[c] = seg_n;
        end
        fd_end = frame_done;
    endtask

    task automatic sync_frame(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 2 * FL + 10);
        pend_tb = 1'b0;
        if (frame_done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL sync_%s: frame_done got %b want 1 within %0d clocks", name, frame_done, n);
        end
    endtask

    task automatic drive_load(input logic [15:0] d);
        data_i = d;
        load_i = 1'b1;
        if (pend_tb)
            void'(exp_q.pop_back());
        exp_q.push_back('{data: d, en: digit_en_i, lit: lit_now});
        pend_tb = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (anode_n !== 4'hF) begin fails++; $display("FAIL rst_anode: got %b want 1111", anode_n); end
        tests++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL rst_seg: got %b want 1111111", seg_n); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_fd: got %b want 0", frame_done); end
        tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL rst_pend: got %b want 0", pending_o); end
        reset = 1'b1;
        exp_q.push_back('{data: 16'h0000, en: 4'hF, lit: lit_now});
        e = exp_q.pop_front(); grab_frame(); bad = 0; fc = 0;
        for (int c = FL - 1; c >= 0; c--) if ({an_cap[c], sg_cap[c]} !== exp_out(e, c)) begin bad++; fc = c; end
        tests++; if (bad != 0) begin fails++; $display("FAIL frame_reset: %0d bad clocks, c=%0d got %b want %b", bad, fc, {an_cap[fc], sg_cap[fc]}, exp_out(e, fc)); end
        tests++; if (fd_end !== 1'b1) begin fails++; $display("FAIL period_reset: frame_done got %b want 1", fd_end); end
    endtask

    task automatic test_load();
        repeat (5) @(negedge clk);
        drive_load(16'h4321);
        tests++; if (pending_o !== 1'b1) begin fails++; $display("FAIL load_pend_set: got %b want 1", pending_o); end
        sync_frame("load");
        tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL load_pend_clr: got %b want 0", pending_o); end
        e = exp_q.pop_front(); grab_frame(); bad = 0; fc = 0;
        for (int c = FL - 1; c >= 0; c--) if ({an_cap[c], sg_cap[c]} !== exp_out(e, c)) begin bad++; fc = c; end
        tests++; if (bad != 0) begin fails++; $display("FAIL frame_load: %0d bad clocks, c=%0d got %b want %b", bad, fc, {an_cap[fc], sg_cap[fc]}, exp_out(e, fc)); end
        tests++; if (fd_end !== 1'b1) begin fails++; $display("FAIL period_load: frame_done got %b want 1", fd_end); end
    endtask

    task automatic test_pending();
        int n = 0;
        repeat (12) @(negedge clk);
        drive_load(16'hFFFF);
        bad = 0;
        while (frame_done !== 1'b1 && n < 2 * FL) begin
            if (pending_o !== 1'b1 || seg_n === 7'h0E) bad++;
            @(negedge clk);
            n++;
        end
        if (frame_done !== 1'b1) bad++;
        pend_tb = 1'b0;
        tests++; if (bad != 0) begin fails++; $display("FAIL pend_window: %0d bad clocks (pending low or F shown early), got %0d want 0", bad, bad); end
        tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL pend_clr: got %b want 0", pending_o); end
        e = exp_q.pop_front(); grab_frame(); bad = 0; fc = 0;
        for (int c = FL - 1; c >= 0; c--) if ({an_cap[c], sg_cap[c]} !== exp_out(e, c)) begin bad++; fc = c; end
        tests++; if (bad != 0) begin fails++; $display("FAIL frame_ffff: %0d bad clocks, c=%0d got %b want %b", bad, fc, {an_cap[fc], sg_cap[fc]}, exp_out(e, fc)); end
        tests++; if (fd_end !== 1'b1) begin fails++; $display("FAIL period_ffff: frame_done got %b want 1", fd_end); end
    endtask

    task automatic test_boundary_load();
        repeat (FL - 1) @(negedge clk);
        drive_load(16'h5A6B);
        pend_tb = 1'b0;
        tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL bnd_fd: got %b want 1", frame_done); end
        tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL bnd_pend: got %b want 0", pending_o); end
        e = exp_q.pop_front(); grab_frame(); bad = 0; fc = 0;
        for (int c = FL - 1; c >= 0; c--) if ({an_cap[c], sg_cap[c]} !== exp_out(e, c)) begin bad++; fc = c; end
        tests++; if (bad != 0) begin fails++; $display("FAIL frame_bnd: %0d bad clocks, c=%0d got %b want %b", bad, fc, {an_cap[fc], sg_cap[fc]}, exp_out(e, fc)); end
        tests++; if (fd_end !== 1'b1) begin fails++; $display("FAIL period_bnd: frame_done got %b want 1", fd_end); end
    endtask

    task automatic test_digit_en();
        digit_en_i = 4'b0101;
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back('{data: 16'h5A6B, en: 4'b0101, lit: lit_now});
            e = exp_q.pop_front(); grab_frame(); bad = 0; fc = 0;
            for (int c = FL - 1; c >= 0; c--) if ({an_cap[c], sg_cap[c]} !== exp_out(e, c)) begin bad++; fc = c; end
            tests++; if (bad != 0) begin fails++; $display("FAIL frame_en%0d: %0d bad clocks, c=%0d got %b want %b", f, bad, fc, {an_cap[fc], sg_cap[fc]}, exp_out(e, fc)); end
            tests++; if (fd_end !== 1'b1) begin fails++; $display("FAIL period_en%0d: frame_done got %b want 1", f, fd_end); end
        end
        digit_en_i = 4'hF;
    endtask

    task automatic test_back_to_back();
        repeat (5) @(negedge clk);
        drive_load(16'hAAAA);
        drive_load(16'h9876);
        sync_frame("b2b");
        e = exp_q.pop_front(); grab_frame(); bad = 0; fc = 0;
        for (int c = FL - 1; c >= 0; c--) if ({an_cap[c], sg_cap[c]} !== exp_out(e, c)) begin bad++; fc = c; end
        tests++; if (bad != 0) begin fails++; $display("FAIL frame_b2b: %0d bad clocks, c=%0d got %b want %b", bad, fc, {an_cap[fc], sg_cap[fc]}, exp_out(e, fc)); end
        tests++; if (fd_end !== 1'b1) begin fails++; $display("FAIL period_b2b: frame_done got %b want 1", fd_end); end
    endtask

    task automatic test_mid_reset();
        repeat (2 * SL + 3) @(negedge clk);
        tests++; if (anode_n !== 4'b1011) begin fails++; $display("FAIL mid_pre_anode: got %b want 1011", anode_n); end
        #2 reset = 1'b0;
        #1;
        tests++; if (anode_n !== 4'hF) begin fails++; $display("FAIL mid_anode: got %b want 1111", anode_n); end
        tests++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL mid_seg: got %b want 1111111", seg_n); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL mid_fd: got %b want 0", frame_done); end
        tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL mid_pend: got %b want 0", pending_o); end
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        pend_tb = 1'b0;
        exp_q.push_back('{data: 16'h0000, en: 4'hF, lit: lit_now});
        e = exp_q.pop_front(); grab_frame(); bad = 0; fc = 0;
        for (int c = FL - 1; c >= 0; c--) if ({an_cap[c], sg_cap[c]} !== exp_out(e, c)) begin bad++; fc = c; end
        tests++; if (bad != 0) begin fails++; $display("FAIL frame_restart: %0d bad clocks, c=%0d got %b want %b", bad, fc, {an_cap[fc], sg_cap[fc]}, exp_out(e, fc)); end
        tests++; if (fd_end !== 1'b1) begin fails++; $display("FAIL period_restart: frame_done got %b want 1", fd_end); end
    endtask

`ifdef SEG_MUX_DIM_EN
    task automatic test_dim();
        int b [2] = '{7, 15};
        for (int k = 0; k < 2; k++) begin
            bright_i = 4'(b[k]);
            sync_frame("dim");
            lit_now = 5'(((b[k] + 1) * RD) >> 4);
            exp_q.push_back('{data: 16'h0000, en: 4'hF, lit: lit_now});
            e = exp_q.pop_front(); grab_frame(); bad = 0; fc = 0;
            for (int c = FL - 1; c >= 0; c--) if ({an_cap[c], sg_cap[c]} !== exp_out(e, c)) begin bad++; fc = c; end
            tests++; if (bad != 0) begin fails++; $display("FAIL frame_dim%0d: %0d bad clocks, c=%0d got %b want %b", b[k], bad, fc, {an_cap[fc], sg_cap[fc]}, exp_out(e, fc)); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_pending();
        test_boundary_load();
        test_digit_en();
        test_back_to_back();
        test_mid_reset();
`ifdef SEG_MUX_DIM_EN
        test_dim();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
